// File: rtl/clint_if.sv
// Single-beat valid/ready request/response channel between the memory
// distributor (master) and the core-local interruptor (slave).
interface clint_if;
   logic        clint_valid_i;
   logic        clint_ready_o;
   logic [63:0] clint_data_read_o;
   logic [63:0] clint_data_write_i;
   logic [63:0] clint_addr_i;
   logic [1:0]  clint_size_i;
   logic [1:0]  clint_resp_o;
   logic        clint_req_i;

   modport master (
      output clint_valid_i, clint_data_write_i, clint_addr_i, clint_size_i, clint_req_i,
      input  clint_ready_o, clint_data_read_o, clint_resp_o
   );

   modport slave (
      input  clint_valid_i, clint_data_write_i, clint_addr_i, clint_size_i, clint_req_i,
      output clint_ready_o, clint_data_read_o, clint_resp_o
   );
endinterface

// File: rtl/clint.sv
// Core-local interruptor: 64-bit mtime with prescaler, mtimecmp, and a
// registered machine-timer interrupt level; registers reached over clint_if.
module clint #(
   parameter int unsigned MTIME_DIV     = 1,
   parameter logic [63:0] MTIME_ADDR    = 64'h0000_0000_0200_BFF8,
   parameter logic [63:0] MTIMECMP_ADDR = 64'h0000_0000_0200_4000
) (
   input  logic   clk,
   input  logic   rst,
   clint_if.slave bus,
   output logic   clint_timer_int_o
);

   localparam int unsigned   PW      = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(MTIME_DIV - 1);

   typedef enum logic {IDLE, RESP} state_t;

   state_t      state, state_n;
   logic [63:0] mtime, mtimecmp;
   logic [PW-1:0] pre;
   logic [63:0] mask, wr_time, wr_cmp;
   logic        accept, hit_time, hit_cmp, tick, wr_time_en, wr_cmp_en;

   assign accept     = (state == IDLE) && bus.clint_valid_i;
   assign hit_time   = (bus.clint_addr_i == MTIME_ADDR);
   assign hit_cmp    = (bus.clint_addr_i == MTIMECMP_ADDR);
   assign wr_time_en = accept && bus.clint_req_i && hit_time;
   assign wr_cmp_en  = accept && bus.clint_req_i && hit_cmp;
   assign tick       = (pre == PRE_MAX);

   assign bus.clint_ready_o = (state == RESP);

   always_comb begin
      mask = '0;
      case (bus.clint_size_i)
         2'b00:   mask = 64'h0000_0000_0000_00FF;
         2'b01:   mask = 64'h0000_0000_0000_FFFF;
         2'b10:   mask = 64'h0000_0000_FFFF_FFFF;
         default: mask = '1;
      endcase
   end

   assign wr_time = (mtime    & ~mask) | (bus.clint_data_write_i & mask);
   assign wr_cmp  = (mtimecmp & ~mask) | (bus.clint_data_write_i & mask);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (bus.clint_valid_i) state_n = RESP;
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // A software write to mtime overrides a coincident tick and restarts the prescaler.
   always_ff @(posedge clk) begin
      if (rst) begin
         mtime <= '0;
         pre   <= '0;
      end else if (wr_time_en) begin
         mtime <= wr_time;
         pre   <= '0;
      end else if (tick) begin
         mtime <= mtime + 64'd1;
         pre   <= '0;
      end else begin
         pre   <= pre + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)            mtimecmp <= '1;
      else if (wr_cmp_en) mtimecmp <= wr_cmp;
   end

   always_ff @(posedge clk) begin
      if (rst) clint_timer_int_o <= 1'b0;
      else     clint_timer_int_o <= (mtime >= mtimecmp);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.clint_data_read_o <= '0;
         bus.clint_resp_o      <= 2'b00;
      end else if (accept) begin
         if (hit_time || hit_cmp) begin
            bus.clint_resp_o      <= 2'b00;
            bus.clint_data_read_o <= bus.clint_req_i ? 64'd0 : (hit_time ? mtime : mtimecmp);
         end else begin
            bus.clint_resp_o      <= 2'b10;
            bus.clint_data_read_o <= '0;
         end
      end
   end

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: a divide-by-1 instance for bus/compare/wrap
// behaviour and a divide-by-4 instance for prescaler restart.
module tb_clint;

   localparam logic [63:0] A_TIME = 64'h0000_0000_0200_BFF8;
   localparam logic [63:0] A_CMP  = 64'h0000_0000_0200_4000;
   localparam logic [63:0] A_BAD  = 64'h0000_0000_0200_0000;
   localparam logic [63:0] ALL1   = 64'hFFFF_FFFF_FFFF_FFFF;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic irq1, irq4;
   int   checks = 0;
   int   errors = 0;

   clint_if bus1();
   clint_if bus4();

   clint #(.MTIME_DIV(1)) u1 (.clk(clk), .rst(rst), .bus(bus1), .clint_timer_int_o(irq1));
   clint #(.MTIME_DIV(4)) u4 (.clk(clk), .rst(rst), .bus(bus4), .clint_timer_int_o(irq4));

   always #5 clk = ~clk;

   typedef struct {
      logic        req;
      logic [63:0] addr;
      logic [1:0]  size;
      logic [63:0] wdata;
      logic [63:0] exp_data;
      logic [1:0]  exp_resp;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int d, input logic v, input logic req, input logic [63:0] addr,
                        input logic [1:0] size, input logic [63:0] wdata);
      if (d == 0) begin
         bus1.clint_valid_i = v; bus1.clint_req_i = req; bus1.clint_addr_i = addr;
         bus1.clint_size_i = size; bus1.clint_data_write_i = wdata;
      end else begin
         bus4.clint_valid_i = v; bus4.clint_req_i = req; bus4.clint_addr_i = addr;
         bus4.clint_size_i = size; bus4.clint_data_write_i = wdata;
      end
   endtask

   function automatic logic rdy(input int d);
      return (d == 0) ? bus1.clint_ready_o : bus4.clint_ready_o;
   endfunction

   // Accept edge, sample the response cycle, then the return-to-idle edge.
   task automatic txn(input int d, input logic req, input logic [63:0] addr, input logic [1:0] size,
                      input logic [63:0] wdata, output logic [63:0] rd, output logic [1:0] rsp,
                      output logic irq_resp);
      drive(d, 1'b1, req, addr, size, wdata);
      step();
      drive(d, 1'b0, 1'b0, '0, 2'b00, '0);
      chk("ready_n_plus_1", {63'd0, rdy(d)}, 64'd1);
      rd       = (d == 0) ? bus1.clint_data_read_o : bus4.clint_data_read_o;
      rsp      = (d == 0) ? bus1.clint_resp_o : bus4.clint_resp_o;
      irq_resp = (d == 0) ? irq1 : irq4;
      step();
      chk("ready_drop_n_plus_2", {63'd0, rdy(d)}, 64'd0);
   endtask

   initial begin
      logic [63:0] rd;
      logic [1:0]  rsp;
      logic        ir;

      drive(0, 1'b0, 1'b0, '0, 2'b00, '0);
      drive(1, 1'b0, 1'b0, '0, 2'b00, '0);

      vecs[0]  = '{1'b1, A_CMP, 2'b11, 64'h1122_3344_5566_7788, 64'd0, 2'b00};
      vecs[1]  = '{1'b0, A_CMP, 2'b11, 64'd0, 64'h1122_3344_5566_7788, 2'b00};
      vecs[2]  = '{1'b1, A_CMP, 2'b00, 64'h5555_5555_5555_55AA, 64'd0, 2'b00};
      vecs[3]  = '{1'b0, A_CMP, 2'b00, 64'd0, 64'h1122_3344_5566_77AA, 2'b00};
      vecs[4]  = '{1'b1, A_CMP, 2'b10, 64'hFFFF_0000_DEAD_BEEF, 64'd0, 2'b00};
      vecs[5]  = '{1'b0, A_CMP, 2'b10, 64'd0, 64'h1122_3344_DEAD_BEEF, 2'b00};
      vecs[6]  = '{1'b1, A_CMP, 2'b01, 64'h0000_0000_0001_2345, 64'd0, 2'b00};
      vecs[7]  = '{1'b0, A_CMP, 2'b01, 64'd0, 64'h1122_3344_DEAD_2345, 2'b00};
      vecs[8]  = '{1'b1, A_BAD, 2'b11, 64'h0000_0000_0000_BEEF, 64'd0, 2'b10};
      vecs[9]  = '{1'b0, A_BAD, 2'b11, 64'd0, 64'd0, 2'b10};
      vecs[10] = '{1'b0, A_CMP, 2'b11, 64'd0, 64'h1122_3344_DEAD_2345, 2'b00};

      // Reset, idle 10 cycles, read mtime
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_ready", {63'd0, bus1.clint_ready_o}, 64'd0);
      chk("rst_data", bus1.clint_data_read_o, 64'd0);
      chk("rst_resp", {62'd0, bus1.clint_resp_o}, 64'd0);
      chk("rst_irq", {63'd0, irq1}, 64'd0);
      chk("rst_irq_div4", {63'd0, irq4}, 64'd0);
      for (int i = 0; i < 10; i++) step();
      chk("idle_ready", {63'd0, bus1.clint_ready_o}, 64'd0);
      txn(0, 1'b0, A_TIME, 2'b11, '0, rd, rsp, ir);
      chk("read_mtime_after_10", rd, 64'd10);
      chk("read_mtime_resp", {62'd0, rsp}, 64'd0);
      chk("read_mtime_irq", {63'd0, ir}, 64'd0);

      // Table: partial writes to mtimecmp and bad-address accesses
      for (int i = 0; i < 11; i++) begin
         txn(0, vecs[i].req, vecs[i].addr, vecs[i].size, vecs[i].wdata, rd, rsp, ir);
         chk($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
         chk($sformatf("vec%0d_resp", i), {62'd0, rsp}, {62'd0, vecs[i].exp_resp});
         chk($sformatf("vec%0d_irq", i), {63'd0, irq1}, 64'd0);
      end

      // Compare hit: mtime=5 then mtimecmp=0x20; current mtime is 8 afterwards
      txn(0, 1'b1, A_TIME, 2'b11, 64'd5, rd, rsp, ir);
      txn(0, 1'b1, A_CMP, 2'b11, 64'h20, rd, rsp, ir);
      chk("cmp_write_irq_resp", {63'd0, ir}, 64'd0);
      for (int i = 0; i < 40; i++) begin
         chk($sformatf("cmp_irq_t%0d", 8 + i), {63'd0, irq1}, {63'd0, ((8 + i - 1) >= 32)});
         step();
      end
      txn(0, 1'b1, A_CMP, 2'b11, ALL1, rd, rsp, ir);
      chk("cmp_raise_irq_n_plus_1", {63'd0, ir}, 64'd1);
      chk("cmp_raise_irq_n_plus_2", {63'd0, irq1}, 64'd0);

      // Wrap with write/tick collision (every edge ticks at divide-by-1)
      txn(0, 1'b1, A_TIME, 2'b11, 64'hFFFF_FFFF_FFFF_FFFE, rd, rsp, ir);
      chk("wrap_irq_fffe", {63'd0, irq1}, 64'd0);
      txn(0, 1'b0, A_TIME, 2'b11, '0, rd, rsp, ir);
      chk("wrap_read_ffff", rd, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("wrap_irq_ffff", {63'd0, ir}, 64'd1);
      chk("wrap_irq_zero", {63'd0, irq1}, 64'd0);
      txn(0, 1'b0, A_TIME, 2'b11, '0, rd, rsp, ir);
      chk("wrap_read_after", rd, 64'd1);

      // Bad-address write leaves mtime counting undisturbed
      txn(0, 1'b1, A_TIME, 2'b11, 64'h1000, rd, rsp, ir);
      txn(0, 1'b1, A_BAD, 2'b11, 64'hDEAD, rd, rsp, ir);
      chk("bad_wr_resp", {62'd0, rsp}, 64'd2);
      chk("bad_wr_data", rd, 64'd0);
      txn(0, 1'b0, A_TIME, 2'b11, '0, rd, rsp, ir);
      chk("bad_wr_mtime", rd, 64'h1003);

      // Divide-by-4: write mtime=0x100 with prescaler at 2; tick lands 4 edges later
      txn(1, 1'b1, A_CMP, 2'b11, 64'h101, rd, rsp, ir);
      txn(1, 1'b1, A_TIME, 2'b11, 64'd0, rd, rsp, ir);
      step();
      txn(1, 1'b1, A_TIME, 2'b11, 64'h100, rd, rsp, ir);
      chk("div4_irq_e0", {63'd0, ir}, 64'd0);
      chk("div4_irq_e1", {63'd0, irq4}, 64'd0);
      for (int i = 2; i <= 5; i++) begin
         step();
         chk($sformatf("div4_irq_e%0d", i), {63'd0, irq4}, {63'd0, (i == 5)});
      end
      txn(1, 1'b0, A_TIME, 2'b11, '0, rd, rsp, ir);
      chk("div4_read_mtime", rd, 64'h101);

      // Reset while a response is pending
      txn(0, 1'b1, A_CMP, 2'b11, 64'd0, rd, rsp, ir);
      chk("cmp_zero_irq", {63'd0, irq1}, 64'd1);
      drive(0, 1'b1, 1'b0, A_TIME, 2'b11, '0);
      step();
      chk("midrst_ready_before", {63'd0, bus1.clint_ready_o}, 64'd1);
      drive(0, 1'b0, 1'b0, '0, 2'b00, '0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_ready", {63'd0, bus1.clint_ready_o}, 64'd0);
      chk("midrst_data", bus1.clint_data_read_o, 64'd0);
      chk("midrst_resp", {62'd0, bus1.clint_resp_o}, 64'd0);
      chk("midrst_irq", {63'd0, irq1}, 64'd0);
      txn(0, 1'b0, A_TIME, 2'b11, '0, rd, rsp, ir);
      chk("midrst_mtime", rd, 64'd0);
      txn(0, 1'b0, A_CMP, 2'b11, '0, rd, rsp, ir);
      chk("midrst_mtimecmp", rd, ALL1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/clint.md
# clint

Core-local interruptor holding the 64-bit machine timer `mtime` and its compare register `mtimecmp`. Sits directly downstream of the memory/CLINT distributor on its CLINT-side port: accepts single-beat reads and writes to `MTIME_ADDR` / `MTIMECMP_ADDR` over the same valid/ready/req/size/resp handshake. Drives the machine-timer interrupt level to the CSR/trap unit.

## Interface
- `MTIME_DIV`, default 1: core-clock cycles per `mtime` increment; legal range ≥1.
- `clk`  in  1: single clock; every register updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `clint_valid_i`  in  1: request valid; held by the upstream until `clint_ready_o`.
- `clint_ready_o`  out  1: one-cycle completion pulse.
- `clint_data_read_o`  out  64: read data, valid while `clint_ready_o`=1.
- `clint_data_write_i`  in  64: write data, LSB-aligned.
- `clint_addr_i`  in  64: byte address.
- `clint_size_i`  in  2: 00 byte, 01 half, 10 word, 11 double.
- `clint_resp_o`  out  2: 00 OKAY, 10 SLVERR; valid while `clint_ready_o`=1.
- `clint_req_i`  in  1: 0 read, 1 write.
- `clint_timer_int_o`  out  1: machine timer interrupt pending (level).

## Operation
- State machine has two states.
  - IDLE: `clint_ready_o`=0. When `clint_valid_i`=1, the block accepts the request on that edge and moves to RESP.
  - RESP: `clint_ready_o`=1 for exactly this cycle, then an unconditional return to IDLE. Valid is not sampled while in RESP.
- Address decode:
  - hit_time = addr==`MTIME_ADDR`.
  - hit_cmp = addr==`MTIMECMP_ADDR`.
  - Neither hit: no register changes; read data 0; resp 10.
- Read: data register captures the pre-edge value of the selected register at the accept edge (before that edge's increment). Full 64 bits are returned regardless of size; the upstream extends or truncates. Resp 00.
- Write: byte-enable mask from size. 00 updates bits [7:0], 01 [15:0], 10 [31:0], 11 [63:0]. Unmasked bits are kept. Resp 00. Read data register is 0.
- `mtime` counting:
  - Prescaler `pre` counts 0..MTIME_DIV-1.
  - When `pre`==MTIME_DIV-1, `mtime` increments by 1 and `pre` returns to 0.
  - MTIME_DIV=1 means `mtime` increments every cycle.
  - Arithmetic is modulo 2^64: 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- Write to `mtime` on the same edge as a tick: the write wins, with no increment that edge. Any `mtime` write also clears `pre` to 0.
- Write to `mtimecmp` does not touch `mtime` or `pre`.
- Interrupt: `clint_timer_int_o` is registered = (`mtime` ≥ `mtimecmp`), unsigned, evaluated on pre-edge values. It deasserts only when the comparison becomes false (software raises `mtimecmp` or lowers `mtime`).

## Timing
- Reset (`rst`=1 at an edge):
  - state IDLE, `clint_ready_o`=0, `clint_data_read_o`=0, `clint_resp_o`=00.
  - `mtime`=0, `pre`=0, `mtimecmp`=0xFFFF_FFFF_FFFF_FFFF, `clint_timer_int_o`=0.
- Reset mid-transaction (state RESP): the pending response is dropped and `clint_ready_o` is 0 the next cycle. The upstream re-issues.
- Latency: valid rising in cycle n → `clint_ready_o`=1 in cycle n+1 → IDLE in n+2. Back-to-back requests therefore complete at most every 2 cycles.
- Write effect is visible in `mtime`/`mtimecmp` from cycle n+1. The interrupt reflects it from cycle n+2.
- `mtime` keeps counting during every state, including RESP.
- Outputs `clint_data_read_o` and `clint_resp_o` hold their last values in IDLE. Consumers sample them only with ready.

## Test plan
- Reset then idle: hold `rst` 1 cycle, run 10 cycles with MTIME_DIV=1, read `mtime`.
  - Ready arrives 1 cycle after valid, data equals the `mtime` value at the accept edge (10 + cycles elapsed before accept), resp 00.
  - `clint_timer_int_o`=0 throughout.
- Compare hit: write `mtimecmp`=0x20 size 11 at `mtime`≈5.
  - `clint_timer_int_o` stays 0 until the cycle after `mtime` reaches 0x20, then stays 1.
  - Writing `mtimecmp`=0xFFFF_FFFF_FFFF_FFFF clears it 2 cycles after accept.
- Partial write: `mtimecmp`=0x1122_3344_5566_7788, write 0xAA size 00.
  - Readback is 0x1122_3344_5566_77AA.
  - Then write 0xDEADBEEF size 10: readback 0x1122_3344_DEAD_BEEF.
- Wrap and collision: write `mtime`=0xFFFF_FFFF_FFFF_FFFE on an edge that is also a tick.
  - `mtime` is ...FFFE, not ...FFFF, in the next cycle.
  - Then ...FFFF, then 0x0 on the following ticks.
- Prescaler with MTIME_DIV=4: `mtime` advances once per 4 cycles.
  - Writing `mtime`=0x100 mid-period gives the next increment exactly 4 cycles after the write edge.
- Bad address 0x0200_0000 read and write: ready after 1 cycle, resp 10, read data 0, both timer registers unchanged.
